// File: rtl/ex_pkg.sv
// Shared opcodes, result classes and divider state encodings for the execute stage.
// Opcode values match the decoder's `AluOpBus / `AluSelBus definitions.
package ex_pkg;

  localparam logic [7:0] EXE_NOP_OP  = 8'b00000000;
  localparam logic [7:0] EXE_AND_OP  = 8'b00100100;
  localparam logic [7:0] EXE_OR_OP   = 8'b00100101;
  localparam logic [7:0] EXE_XOR_OP  = 8'b00100110;
  localparam logic [7:0] EXE_NOR_OP  = 8'b00100111;
  localparam logic [7:0] EXE_LUI_OP  = 8'b01011100;
  localparam logic [7:0] EXE_SLL_OP  = 8'b01111100;
  localparam logic [7:0] EXE_SRL_OP  = 8'b00000010;
  localparam logic [7:0] EXE_SRA_OP  = 8'b00000011;
  localparam logic [7:0] EXE_DIV_OP  = 8'b00011010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b00011011;

  localparam logic [2:0] EXE_RES_NOP   = 3'b000;
  localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [2:0] EXE_RES_SHIFT = 3'b010;
  localparam logic [2:0] EXE_RES_ARITH = 3'b100;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_DIVZERO = 2'd1;
  localparam logic [1:0] ST_BUSY    = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  // Magnitude of an operand; only signed operands are treated as two's complement.
  function automatic logic [31:0] abs_mag(input logic sgn, input logic [31:0] v);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/ex_div.sv
// Radix-2 restoring divider: one shift-subtract step per cycle on operand magnitudes,
// with the sign fix-up applied to the result presented in DONE.
//
// state      | meaning
// -----------+------------------------------------------------------
// ST_IDLE    | waiting for start_i; latches magnitudes and signs
// ST_DIVZERO | divisor was zero; result forced to 0
// ST_BUSY    | one restoring step per cycle, cnt 0..DIV_CYCLES-1
// ST_DONE    | result valid, ready_o high for one cycle
module div
  import ex_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_i,
  input  logic [31:0] op1_i,
  input  logic [31:0] op2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  logic [1:0]  state;
  logic [5:0]  cnt;
  logic [31:0] rem;
  logic [31:0] quo;
  logic [31:0] dvs;
  logic        neg_q;
  logic        neg_r;

  logic [32:0] shifted;
  logic        fits;
  logic [31:0] diff;

  // The running remainder is always below the divisor, so a 32-bit difference is exact.
  assign shifted = {rem, quo[31]};
  assign fits    = shifted >= {1'b0, dvs};
  assign diff    = shifted[31:0] - dvs;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      rem   <= '0;
      quo   <= '0;
      dvs   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            quo   <= abs_mag(signed_i, op1_i);
            dvs   <= abs_mag(signed_i, op2_i);
            rem   <= '0;
            cnt   <= '0;
            neg_q <= signed_i & (op1_i[31] ^ op2_i[31]);
            neg_r <= signed_i & op1_i[31];
            state <= (op2_i == 32'd0) ? ST_DIVZERO : ST_BUSY;
          end
        end
        ST_DIVZERO: begin
          if (annul_i) begin
            state <= ST_IDLE;
          end else begin
            quo   <= '0;
            rem   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            state <= ST_DONE;
          end
        end
        ST_BUSY: begin
          if (annul_i) begin
            state <= ST_IDLE;
          end else begin
            rem <= fits ? diff : shifted[31:0];
            quo <= {quo[30:0], fits};
            if (cnt == 6'(DIV_CYCLES - 1)) begin
              state <= ST_DONE;
            end else begin
              cnt <= cnt + 6'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign ready_o  = (state == ST_DONE) && !annul_i;
  assign result_o = ready_o ? {(neg_r ? (~rem + 32'd1) : rem), (neg_q ? (~quo + 32'd1) : quo)}
                            : 64'd0;

endmodule

// File: rtl/ex.sv
// Execute stage: single-cycle logic/shift results plus a multi-cycle divider that
// holds the pipeline via stallreq_o until HI/LO are ready.
module ex
  import ex_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [2:0]  alusel_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic        annul_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        whilo_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        stallreq_o
);

  logic        is_div;
  logic [31:0] logic_res;
  logic [31:0] shift_res;
  logic [63:0] div_result;
  logic        div_ready;

  assign is_div = (aluop_i == EXE_DIV_OP) || (aluop_i == EXE_DIVU_OP);

  always_comb begin
    logic_res = '0;
    case (aluop_i)
      EXE_AND_OP: logic_res = reg1_i & reg2_i;
      EXE_OR_OP:  logic_res = reg1_i | reg2_i;
      EXE_XOR_OP: logic_res = reg1_i ^ reg2_i;
      EXE_NOR_OP: logic_res = ~(reg1_i | reg2_i);
      EXE_LUI_OP: logic_res = reg2_i;
      default:    logic_res = '0;
    endcase
  end

  always_comb begin
    shift_res = '0;
    case (aluop_i)
      EXE_SLL_OP: shift_res = reg2_i << reg1_i[4:0];
      EXE_SRL_OP: shift_res = reg2_i >> reg1_i[4:0];
      EXE_SRA_OP: shift_res = 32'($signed(reg2_i) >>> reg1_i[4:0]);
      default:    shift_res = '0;
    endcase
  end

  div #(.DIV_CYCLES(DIV_CYCLES)) u_div (
    .clk      (clk),
    .rst      (rst),
    .signed_i (aluop_i == EXE_DIV_OP),
    .op1_i    (reg1_i),
    .op2_i    (reg2_i),
    .start_i  (is_div && !annul_i),
    .annul_i  (annul_i),
    .result_o (div_result),
    .ready_o  (div_ready)
  );

  // Outputs are held at zero while reset is asserted.
  always_comb begin
    wd_o       = '0;
    wreg_o     = 1'b0;
    wdata_o    = '0;
    whilo_o    = 1'b0;
    hi_o       = '0;
    lo_o       = '0;
    stallreq_o = 1'b0;
    if (!rst) begin
      wd_o   = wd_i;
      wreg_o = wreg_i && (aluop_i != EXE_NOP_OP) && !is_div;
      case (alusel_i)
        EXE_RES_LOGIC: wdata_o = logic_res;
        EXE_RES_SHIFT: wdata_o = shift_res;
        default:       wdata_o = '0;
      endcase
      whilo_o    = div_ready;
      hi_o       = div_result[63:32];
      lo_o       = div_result[31:0];
      stallreq_o = is_div && !div_ready;
    end
  end

endmodule

// File: tb/tb_ex.sv
// Directed and randomized checks of the execute stage against a plain-arithmetic model.
module tb_ex;
  import ex_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  aluop_i = '0;
  logic [2:0]  alusel_i = '0;
  logic [31:0] reg1_i = '0;
  logic [31:0] reg2_i = '0;
  logic [4:0]  wd_i = '0;
  logic        wreg_i = 1'b0;
  logic        annul_i = 1'b0;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        whilo_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        stallreq_o;

  int n_cmp = 0;
  int n_bad = 0;

  ex dut (
    .clk(clk), .rst(rst), .aluop_i(aluop_i), .alusel_i(alusel_i),
    .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
    .annul_i(annul_i), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
    .whilo_o(whilo_o), .hi_o(hi_o), .lo_o(lo_o), .stallreq_o(stallreq_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [7:0] op, input logic [2:0] sel,
                                         input logic [31:0] a, input logic [31:0] b);
    int sh;
    sh = int'(a[4:0]);
    if (sel == EXE_RES_LOGIC) begin
      if (op == EXE_AND_OP) return a & b;
      if (op == EXE_OR_OP)  return a | b;
      if (op == EXE_XOR_OP) return a ^ b;
      if (op == EXE_NOR_OP) return ~(a | b);
      if (op == EXE_LUI_OP) return b;
      return 32'd0;
    end
    if (sel == EXE_RES_SHIFT) begin
      if (op == EXE_SLL_OP) return b << sh;
      if (op == EXE_SRL_OP) return b >> sh;
      if (op == EXE_SRA_OP) return (b >> sh) | (b[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
      return 32'd0;
    end
    return 32'd0;
  endfunction

  task automatic ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r);
    if (b == 32'd0) begin
      q = 32'd0; r = 32'd0;
    end else if (!sgn) begin
      q = a / b; r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'd0;
    end else begin
      q = 32'($signed(a) / $signed(b));
      r = 32'($signed(a) % $signed(b));
    end
  endtask

  task automatic run_alu(input logic [7:0] op, input logic [2:0] sel,
                         input logic [31:0] a, input logic [31:0] b, input logic we);
    logic [4:0] wd;
    wd = 5'($urandom);
    aluop_i = op; alusel_i = sel; reg1_i = a; reg2_i = b; wreg_i = we; wd_i = wd;
    @(negedge clk);
    chk("alu_wdata", wdata_o, ref_alu(op, sel, a, b));
    chk("alu_wreg", 32'(wreg_o), 32'(we && op != EXE_NOP_OP));
    chk("alu_wd", 32'(wd_o), 32'(wd));
    chk("alu_stall", 32'(stallreq_o), 32'd0);
    chk("alu_whilo", 32'(whilo_o), 32'd0);
    @(posedge clk); #1;
  endtask

  // abort_at < 0 runs to completion; otherwise annul (or reset) is raised in that cycle.
  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input int abort_at, input logic by_rst);
    logic [31:0] eq, er;
    logic [4:0]  wd;
    int last, stop, post;
    ref_div(sgn, a, b, eq, er);
    last = (b == 32'd0) ? 2 : 33;
    stop = (abort_at >= 0) ? abort_at : last;
    post = (abort_at >= 0) ? 36 : 2;
    wd = 5'($urandom);
    aluop_i = sgn ? EXE_DIV_OP : EXE_DIVU_OP; alusel_i = EXE_RES_ARITH;
    reg1_i = a; reg2_i = b; wreg_i = 1'b1; wd_i = wd;
    for (int k = 0; k <= stop; k++) begin
      if (k == abort_at) begin
        if (by_rst) rst = 1'b1; else annul_i = 1'b1;
      end
      @(negedge clk);
      if (k == abort_at && by_rst) begin
        chk("rst_stall", 32'(stallreq_o), 32'd0);
        chk("rst_whilo", 32'(whilo_o), 32'd0);
        chk("rst_wd", 32'(wd_o), 32'd0);
        chk("rst_hi", hi_o, 32'd0);
        chk("rst_lo", lo_o, 32'd0);
      end else begin
        chk("div_stall", 32'(stallreq_o), 32'(k < last));
        chk("div_whilo", 32'(whilo_o), 32'(k == last));
        chk("div_wreg", 32'(wreg_o), 32'd0);
        chk("div_wd", 32'(wd_o), 32'(wd));
        if (k == last) begin
          chk("div_hi", hi_o, er);
          chk("div_lo", lo_o, eq);
        end
      end
      @(posedge clk); #1;
    end
    aluop_i = EXE_NOP_OP; alusel_i = EXE_RES_NOP; annul_i = 1'b0; rst = 1'b0;
    for (int k = 0; k < post; k++) begin
      @(negedge clk);
      chk("post_stall", 32'(stallreq_o), 32'd0);
      chk("post_whilo", 32'(whilo_o), 32'd0);
      @(posedge clk); #1;
    end
  endtask

  logic [7:0] ops  [9] = '{EXE_AND_OP, EXE_OR_OP, EXE_XOR_OP, EXE_NOR_OP, EXE_LUI_OP,
                           EXE_SLL_OP, EXE_SRL_OP, EXE_SRA_OP, EXE_NOP_OP};
  logic [2:0] sels [9] = '{EXE_RES_LOGIC, EXE_RES_LOGIC, EXE_RES_LOGIC, EXE_RES_LOGIC,
                           EXE_RES_LOGIC, EXE_RES_SHIFT, EXE_RES_SHIFT, EXE_RES_SHIFT,
                           EXE_RES_NOP};

  initial begin
    // Reset with a live OR op on the inputs: everything must read zero.
    aluop_i = EXE_OR_OP; alusel_i = EXE_RES_LOGIC; reg1_i = 32'h1234_5678;
    reg2_i = 32'h0F0F_0F0F; wreg_i = 1'b1; wd_i = 5'd9;
    @(negedge clk);
    chk("reset_wdata", wdata_o, 32'd0);
    chk("reset_wreg", 32'(wreg_o), 32'd0);
    chk("reset_wd", 32'(wd_o), 32'd0);
    chk("reset_stall", 32'(stallreq_o), 32'd0);
    chk("reset_whilo", 32'(whilo_o), 32'd0);
    chk("reset_hilo", hi_o | lo_o, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_alu(EXE_OR_OP, EXE_RES_LOGIC, 32'h0000_F0F0, 32'h00FF_0000, 1'b1);
    chk("or_fixed", wdata_o, 32'h00FF_F0F0);
    run_alu(EXE_SRA_OP, EXE_RES_SHIFT, 32'd4, 32'h8000_0000, 1'b1);
    run_alu(EXE_SLL_OP, EXE_RES_SHIFT, 32'd0, 32'hDEAD_BEEF, 1'b1);
    run_alu(EXE_SRL_OP, EXE_RES_SHIFT, 32'd31, 32'h8000_0000, 1'b1);
    run_alu(EXE_LUI_OP, EXE_RES_LOGIC, 32'hFFFF_FFFF, 32'hABCD_0000, 1'b0);
    run_alu(EXE_AND_OP, EXE_RES_ARITH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);

    run_div(1'b0, 32'd100, 32'd7, -1, 1'b0);
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, -1, 1'b0);
    run_div(1'b1, 32'd7, 32'd0, -1, 1'b0);
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b0);
    run_div(1'b0, 32'hFFFF_FFFF, 32'd1, -1, 1'b0);
    run_div(1'b0, 32'd100, 32'd7, 10, 1'b0);
    run_div(1'b0, 32'd100, 32'd7, 10, 1'b1);
    run_div(1'b0, 32'd100, 32'd7, -1, 1'b0);

    for (int i = 0; i < 60; i++) begin
      int idx;
      idx = int'($urandom_range(0, 8));
      run_alu(ops[idx], sels[idx], $urandom, $urandom, 1'($urandom));
    end

    for (int i = 0; i < 8; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (b == 32'd0) b = 32'd3;
      if ($urandom_range(0, 1) == 1) b = ~b + 32'd1;
      run_div(1'($urandom), a, b, -1, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
